wash_sequencer: RTL and testbench

//  Wash-program sequencer for the washing-machine controller. Runs the selected program

---
 rtl/wash_sequencer.sv | 168 ++++++++++++++++
 tb/tb_wash_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: WASH -> RINSE (xN) -> SPIN -> DONE.
// One clk_s cycle is one second. Start/pause share a single button.
module wash_sequencer #(
    parameter int unsigned WASH_T     = 9,
    parameter int unsigned RINSE_T    = 6,
    parameter int unsigned SPIN_T     = 3,
    parameter int unsigned RINSE_REPS = 2,
    parameter int unsigned FILL_T     = 2
) (
    input  logic       clk_s,
    input  logic       reset,
    input  logic       power_on,
    input  logic       start_btn,
    input  logic [1:0] mode,
    output logic       finish,
    output logic       pause,
    output logic [2:0] phase,
    output logic [7:0] remaining,
    output logic       water_in,
    output logic       motor_on,
    output logic       drain
);

    localparam int unsigned PW  = 6;
    localparam int unsigned RMW = 8;

    localparam logic [RMW-1:0] TOT_FULL  = RMW'(WASH_T + RINSE_REPS * RINSE_T + SPIN_T);
    localparam logic [RMW-1:0] TOT_QUICK = RMW'(WASH_T + RINSE_T + SPIN_T);
    localparam logic [RMW-1:0] TOT_SPIN  = RMW'(SPIN_T);
    localparam logic [RMW-1:0] TOT_RS    = RMW'(RINSE_T + SPIN_T);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  phase_left, phase_left_nxt;
    logic [RMW-1:0] remaining_nxt;
    logic [1:0]     rinse_cnt, rinse_cnt_nxt;
    logic [1:0]     rinse_target;
    logic [1:0]     mode_q, mode_nxt;
    logic           pause_nxt, finish_nxt, water_nxt, motor_nxt, drain_nxt;
    logic           running_nxt;
    logic           start_btn_q;
    logic           start_edge;

    assign start_edge   = start_btn & ~start_btn_q;
    assign rinse_target = (mode_q == 2'b00) ? 2'(RINSE_REPS) : 2'd1;
    assign phase        = state;

    // Next-state, counters and registered actuator values
    always_comb begin
        state_nxt      = state;
        phase_left_nxt = phase_left;
        remaining_nxt  = remaining;
        rinse_cnt_nxt  = rinse_cnt;
        mode_nxt       = mode_q;
        pause_nxt      = pause;

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    mode_nxt  = mode;
                    pause_nxt = 1'b0;
                    case (mode)
                        2'b00: begin
                            state_nxt      = S_WASH;
                            phase_left_nxt = PW'(WASH_T);
                            remaining_nxt  = TOT_FULL;
                        end
                        2'b01: begin
                            state_nxt      = S_WASH;
                            phase_left_nxt = PW'(WASH_T);
                            remaining_nxt  = TOT_QUICK;
                        end
                        2'b10: begin
                            state_nxt      = S_SPIN;
                            phase_left_nxt = PW'(SPIN_T);
                            remaining_nxt  = TOT_SPIN;
                        end
                        default: begin
                            state_nxt      = S_RINSE;
                            phase_left_nxt = PW'(RINSE_T);
                            remaining_nxt  = TOT_RS;
                            rinse_cnt_nxt  = 2'd1;
                        end
                    endcase
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                if (start_edge) pause_nxt = ~pause;
                // A pausing press consumes its cycle; an unpausing press counts
                if (!pause_nxt) begin
                    remaining_nxt  = remaining - RMW'(1);
                    phase_left_nxt = phase_left - PW'(1);
                    if (phase_left == PW'(1)) begin
                        if (state == S_WASH) begin
                            state_nxt      = S_RINSE;
                            phase_left_nxt = PW'(RINSE_T);
                            rinse_cnt_nxt  = 2'd1;
                        end else if (state == S_RINSE && rinse_cnt < rinse_target) begin
                            phase_left_nxt = PW'(RINSE_T);
                            rinse_cnt_nxt  = rinse_cnt + 2'd1;
                        end else if (state == S_RINSE) begin
                            state_nxt      = S_SPIN;
                            phase_left_nxt = PW'(SPIN_T);
                        end else begin
                            state_nxt      = S_DONE;
                            phase_left_nxt = '0;
                        end
                    end
                end
            end
            S_DONE: begin
                state_nxt     = S_IDLE;
                remaining_nxt = '0;
                pause_nxt     = 1'b0;
                rinse_cnt_nxt = '0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        running_nxt = (state_nxt == S_WASH || state_nxt == S_RINSE || state_nxt == S_SPIN)
                      && !pause_nxt;
        finish_nxt  = (state_nxt == S_DONE);
        motor_nxt   = running_nxt;
        drain_nxt   = running_nxt && (state_nxt == S_SPIN);
        water_nxt   = running_nxt &&
                      ((state_nxt == S_WASH  && phase_left_nxt > PW'(WASH_T - FILL_T)) ||
                       (state_nxt == S_RINSE && phase_left_nxt > PW'(RINSE_T - FILL_T)));
    end

    // State and output registers; power loss behaves like reset
    always_ff @(posedge clk_s) begin
        if (reset || !power_on) begin
            state       <= S_IDLE;
            phase_left  <= '0;
            remaining   <= '0;
            rinse_cnt   <= '0;
            mode_q      <= '0;
            pause       <= 1'b0;
            finish      <= 1'b0;
            water_in    <= 1'b0;
            motor_on    <= 1'b0;
            drain       <= 1'b0;
            start_btn_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_left  <= phase_left_nxt;
            remaining   <= remaining_nxt;
            rinse_cnt   <= rinse_cnt_nxt;
            mode_q      <= mode_nxt;
            pause       <= pause_nxt;
            finish      <= finish_nxt;
            water_in    <= water_nxt;
            motor_on    <= motor_nxt;
            drain       <= drain_nxt;
            start_btn_q <= start_btn;
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer with default parameters.
// Expected per-cycle values come from a phase/duration table built in the bench.
module tb_wash_sequencer;

    localparam int WASH_T  = 9;
    localparam int RINSE_T = 6;
    localparam int SPIN_T  = 3;
    localparam int FILL_T  = 2;

    logic       clk_s = 1'b0;
    logic       reset;
    logic       power_on;
    logic       start_btn;
    logic [1:0] mode;
    logic       finish;
    logic       pause;
    logic [2:0] phase;
    logic [7:0] remaining;
    logic       water_in;
    logic       motor_on;
    logic       drain;

    int checks = 0;
    int errors = 0;

    wash_sequencer dut (
        .clk_s     (clk_s),
        .reset     (reset),
        .power_on  (power_on),
        .start_btn (start_btn),
        .mode      (mode),
        .finish    (finish),
        .pause     (pause),
        .phase     (phase),
        .remaining (remaining),
        .water_in  (water_in),
        .motor_on  (motor_on),
        .drain     (drain)
    );

    always #5 clk_s = ~clk_s;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " phase"}, int'(phase), 0);
        check({tag, " remaining"}, int'(remaining), 0);
        check({tag, " finish"}, int'(finish), 0);
        check({tag, " pause"}, int'(pause), 0);
        check({tag, " water"}, int'(water_in), 0);
        check({tag, " motor"}, int'(motor_on), 0);
        check({tag, " drain"}, int'(drain), 0);
    endtask

    function automatic int dur(input int p);
        case (p)
            1:       return WASH_T;
            2:       return RINSE_T;
            default: return SPIN_T;
        endcase
    endfunction

    task automatic wait_finish(input int k0, output int fin_k);
        fin_k = -1;
        for (int k = k0 + 1; k <= k0 + 60; k++) begin
            tick();
            if (finish) begin
                fin_k = k;
                break;
            end
        end
    endtask

    // Run one program uninterrupted, checking every output every cycle
    task automatic run_check(input int m, input bit hold, input bit mid_mode, input bit done_press);
        int seq[$];
        int ph[$];
        int off[$];
        int total;
        int e;
        string t;
        case (m)
            0:       seq = '{1, 2, 2, 3};
            1:       seq = '{1, 2, 3};
            2:       seq = '{3};
            default: seq = '{2, 3};
        endcase
        foreach (seq[s]) begin
            for (int i = 0; i < dur(seq[s]); i++) begin
                ph.push_back(seq[s]);
                off.push_back(i);
            end
        end
        total = ph.size();
        ph.push_back(4); off.push_back(0);
        ph.push_back(0); off.push_back(0);

        start_btn = 1'b0;
        tick();
        mode      = 2'(m);
        start_btn = 1'b1;
        for (int k = 1; k <= ph.size(); k++) begin
            tick();
            e = ph[k-1];
            t = $sformatf("m%0d k%0d", m, k);
            check({t, " phase"}, int'(phase), e);
            check({t, " remaining"}, int'(remaining), (k <= total) ? total + 1 - k : 0);
            check({t, " finish"}, int'(finish), int'(e == 4));
            check({t, " pause"}, int'(pause), 0);
            check({t, " motor"}, int'(motor_on), int'(e >= 1 && e <= 3));
            check({t, " drain"}, int'(drain), int'(e == 3));
            check({t, " water"}, int'(water_in), int'((e == 1 || e == 2) && off[k-1] < FILL_T));
            if (!hold && k == 1) start_btn = 1'b0;
            if (mid_mode && k == 3) mode = 2'(m ^ 3);
            if (done_press && k == total + 1) start_btn = 1'b1;
        end
        start_btn = 1'b0;
        tick();
        check_idle($sformatf("m%0d end", m));
    endtask

    initial begin
        int fin_k;
        reset     = 1'b1;
        power_on  = 1'b1;
        start_btn = 1'b0;
        mode      = 2'b00;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post reset");

        // Full, quick programs
        run_check(0, 1'b0, 1'b0, 1'b0);
        run_check(1, 1'b0, 1'b0, 1'b0);

        // Pause for 5 cycles at remaining=20
        start_btn = 1'b0; tick();
        mode = 2'b00; start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        check("pause pre rem", int'(remaining), 20);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            if (k > 6) tick();
            check($sformatf("paused k%0d pause", k), int'(pause), 1);
            check($sformatf("paused k%0d rem", k), int'(remaining), 20);
            check($sformatf("paused k%0d motor", k), int'(motor_on), 0);
            check($sformatf("paused k%0d phase", k), int'(phase), 1);
        end
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("resume pause", int'(pause), 0);
        check("resume rem", int'(remaining), 19);
        check("resume motor", int'(motor_on), 1);
        wait_finish(11, fin_k);
        check("pause finish cycle", fin_k, 30);
        tick();
        check_idle("pause end");

        // Spin only with a press during DONE; rinse+spin
        run_check(2, 1'b0, 1'b0, 1'b1);
        run_check(3, 1'b0, 1'b0, 1'b0);

        // Power loss during RINSE
        start_btn = 1'b0; tick();
        mode = 2'b00; start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int k = 2; k <= 12; k++) tick();
        check("pwr pre phase", int'(phase), 2);
        power_on = 1'b0;
        tick();
        check_idle("pwr off");
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("pwr off hold%0d finish", k), int'(finish), 0);
            check($sformatf("pwr off hold%0d phase", k), int'(phase), 0);
        end
        power_on = 1'b1;
        tick();
        check_idle("pwr restore");
        run_check(0, 1'b0, 1'b0, 1'b0);

        // Held button across start, mode changed mid-run
        run_check(0, 1'b1, 1'b1, 1'b0);

        // Press coincides with the last WASH second: pause wins, no transition
        start_btn = 1'b0; tick();
        mode = 2'b00; start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int k = 2; k <= 9; k++) tick();
        check("edge1 pre rem", int'(remaining), 16);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("edge1 phase", int'(phase), 1);
        check("edge1 pause", int'(pause), 1);
        check("edge1 rem", int'(remaining), 16);
        tick();
        check("edge1 hold phase", int'(phase), 1);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("edge1 resume phase", int'(phase), 2);
        check("edge1 resume rem", int'(remaining), 15);
        check("edge1 resume water", int'(water_in), 1);
        wait_finish(12, fin_k);
        check("edge1 finish cycle", fin_k, 27);
        tick();
        check_idle("edge1 end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
